// File: rtl/tile_conv_pkg.sv
// Shared constants, scheduler state encoding and cfg_pad bit positions for the
// tiled-convolution DMA scheduler.
package tile_conv_pkg;

  localparam int DEF_IMG_W       = 128;
  localparam int DEF_IMG_H       = 128;
  localparam int DEF_TILE_W      = 32;
  localparam int DEF_TILE_H      = 32;
  localparam int DEF_PIX_PER_CLK = 8;
  localparam int DEF_WIN_SIZE    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // cfg_pad = {top, bottom, left, right}
  localparam int PAD_TOP    = 3;
  localparam int PAD_BOTTOM = 2;
  localparam int PAD_LEFT   = 1;
  localparam int PAD_RIGHT  = 0;

endpackage

// File: rtl/tile_seg_calc.sv
// Combinational tile geometry: halo-extended row range, beat-aligned column
// segment and address of row y, plus the zero-pad flags of tile (tx, ty).
module tile_seg_calc
  import tile_conv_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int TILE_W      = DEF_TILE_W,
  parameter int TILE_H      = DEF_TILE_H,
  parameter int PIX_PER_CLK = DEF_PIX_PER_CLK,
  parameter int WIN_SIZE    = DEF_WIN_SIZE,
  parameter int ADDR_W      = $clog2(IMG_W*IMG_H),
  parameter int LEN_W       = 8
) (
  input  logic [7:0]        tx,
  input  logic [7:0]        ty,
  input  logic [15:0]       y,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_len,
  output logic [15:0]       y0,
  output logic [15:0]       y1,
  output logic [3:0]        cfg_pad
);

  localparam int HALO    = WIN_SIZE / 2;
  localparam int TX_LAST = IMG_W / TILE_W - 1;
  localparam int TY_LAST = IMG_H / TILE_H - 1;

  int x_org, y_org, xs, xe, y_lo, y_hi;

  // All geometry is done in 32-bit int so clamping never wraps.
  always_comb begin
    x_org = int'(tx) * TILE_W;
    y_org = int'(ty) * TILE_H;
    xs    = (x_org > PIX_PER_CLK) ? x_org - PIX_PER_CLK : 0;
    xe    = (x_org + TILE_W + PIX_PER_CLK < IMG_W) ? x_org + TILE_W + PIX_PER_CLK : IMG_W;
    y_lo  = (y_org > HALO) ? y_org - HALO : 0;
    y_hi  = (y_org + TILE_H - 1 + HALO < IMG_H - 1) ? y_org + TILE_H - 1 + HALO : IMG_H - 1;

    req_addr = ADDR_W'(int'(y) * IMG_W + xs);
    req_len  = LEN_W'((xe - xs) / PIX_PER_CLK);
    y0       = 16'(y_lo);
    y1       = 16'(y_hi);

    cfg_pad             = '0;
    cfg_pad[PAD_TOP]    = (int'(ty) == 0);
    cfg_pad[PAD_BOTTOM] = (int'(ty) == TY_LAST);
    cfg_pad[PAD_LEFT]   = (int'(tx) == 0);
    cfg_pad[PAD_RIGHT]  = (int'(tx) == TX_LAST);
  end

endmodule

// File: rtl/tile_conv_sched.sv
// Raster-order tile scheduler: configures the engine per tile, issues one DMA
// row request per halo row, then waits for eng_done. All outputs registered.
module tile_conv_sched
  import tile_conv_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int TILE_W      = DEF_TILE_W,
  parameter int TILE_H      = DEF_TILE_H,
  parameter int PIX_PER_CLK = DEF_PIX_PER_CLK,
  parameter int WIN_SIZE    = DEF_WIN_SIZE,
  parameter int ADDR_W      = $clog2(IMG_W*IMG_H),
  parameter int LEN_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_len,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic [7:0]        cfg_tx,
  output logic [7:0]        cfg_ty,
  output logic [3:0]        cfg_pad,
  input  logic              eng_done,
  output logic [15:0]       tiles_done
);

  localparam int TX_LAST = IMG_W / TILE_W - 1;
  localparam int TY_LAST = IMG_H / TILE_H - 1;

  if (IMG_W % TILE_W != 0) begin : g_chk_w
    $error("IMG_W must be a multiple of TILE_W");
  end
  if (IMG_H % TILE_H != 0) begin : g_chk_h
    $error("IMG_H must be a multiple of TILE_H");
  end
  if (TILE_W % PIX_PER_CLK != 0) begin : g_chk_p
    $error("TILE_W must be a multiple of PIX_PER_CLK");
  end
  if (TX_LAST > 255 || TY_LAST > 255) begin : g_chk_idx
    $error("tile grid exceeds 8-bit tile indices");
  end

  sched_state_t      state, state_n;
  logic [7:0]        tx, ty, tx_n, ty_n;
  logic [15:0]       y, y_n, y_last, tiles_n;
  logic [ADDR_W-1:0] seg_addr;
  logic [LEN_W-1:0]  seg_len;
  logic [15:0]       seg_y0, seg_y1;
  logic [3:0]        seg_pad;
  logic              last_tile, busy_n;

  // Geometry is evaluated on next-cycle indices so every output can be registered.
  tile_seg_calc #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .PIX_PER_CLK(PIX_PER_CLK), .WIN_SIZE(WIN_SIZE), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) u_seg (
    .tx(tx_n), .ty(ty_n), .y(y_n),
    .req_addr(seg_addr), .req_len(seg_len),
    .y0(seg_y0), .y1(seg_y1), .cfg_pad(seg_pad)
  );

  assign last_tile = (tx == 8'(TX_LAST)) && (ty == 8'(TY_LAST));
  assign busy_n    = (state_n == CFG) || (state_n == FETCH) || (state_n == WAIT);

  always_comb begin
    state_n = state;
    tx_n    = tx;
    ty_n    = ty;
    y_n     = y;
    tiles_n = tiles_done;
    unique case (state)
      IDLE: if (start) begin
        state_n = CFG;
        tx_n    = '0;
        ty_n    = '0;
        tiles_n = '0;
      end
      CFG: if (cfg_valid && cfg_ready) state_n = FETCH;
      FETCH: if (req_valid && req_ready) begin
        if (y == y_last) state_n = WAIT;
        else             y_n = y + 16'd1;
      end
      WAIT: if (eng_done) begin
        tiles_n = tiles_done + 16'd1;
        if (last_tile) begin
          state_n = DONE;
        end else begin
          state_n = CFG;
          if (tx == 8'(TX_LAST)) begin
            tx_n = '0;
            ty_n = ty + 8'd1;
          end else begin
            tx_n = tx + 8'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= '0;
      ty         <= '0;
      y          <= '0;
      y_last     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      req_len    <= '0;
      cfg_valid  <= 1'b0;
      cfg_tx     <= '0;
      cfg_ty     <= '0;
      cfg_pad    <= '0;
      tiles_done <= '0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      ty    <= ty_n;
      // While configuring, preload the row walker with this tile's halo range.
      y     <= (state_n == CFG) ? seg_y0 : y_n;
      if (state_n == CFG) y_last <= seg_y1;
      busy       <= busy_n;
      done       <= (state_n == DONE);
      req_valid  <= (state_n == FETCH);
      req_addr   <= (state_n == FETCH) ? seg_addr : '0;
      req_len    <= (state_n == FETCH) ? seg_len : '0;
      cfg_valid  <= (state_n == CFG);
      cfg_tx     <= busy_n ? tx_n : '0;
      cfg_ty     <= busy_n ? ty_n : '0;
      cfg_pad    <= busy_n ? seg_pad : '0;
      tiles_done <= tiles_n;
    end
  end

endmodule

// File: tb/tb_tile_conv_sched.sv
// Bench for tile_conv_sched: a geometry model builds the expected request and
// configuration streams; a negedge monitor captures handshakes and drives the engine.
module tb_tile_conv_sched;

  localparam int IW = 128, IH = 128, TW = 32, TH = 32, PPC = 8, HALO = 1;
  localparam int NTX = IW / TW, NTY = IH / TH, NT = NTX * NTY;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0;
  logic        req_ready = 1'b1, cfg_ready = 1'b1, eng_done = 1'b0;
  logic        busy, done, req_valid, cfg_valid;
  logic [13:0] req_addr;
  logic [7:0]  req_len, cfg_tx, cfg_ty;
  logic [3:0]  cfg_pad;
  logic [15:0] tiles_done;

  tile_conv_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tx(cfg_tx), .cfg_ty(cfg_ty),
    .cfg_pad(cfg_pad), .eng_done(eng_done), .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  int exp_addr[$], exp_len[$], exp_tile[$];
  int cap_addr[$], cap_len[$], cap_tile[$], cap_cfg[$];
  int done_cnt = 0, viol_stab = 0, viol_both = 0, viol_done = 0;
  int tile_idx = -1, rows_seen = 0, rows_need = 0, eng_cd = 0;
  bit eng_go = 0, eng_auto = 0, eng_force = 0, rdy_rand = 0;
  bit prev_req_stall = 0, prev_cfg_stall = 0, prev_done = 0, prev_busy = 0;
  int prev_addr = 0, prev_len = 0, prev_cfg = 0;

  function automatic void tile_geom(input int t, output int y0, output int y1,
                                    output int xs, output int len, output int pad);
    int tx, ty, xo, yo, xe;
    tx  = t % NTX;
    ty  = t / NTX;
    xo  = tx * TW;
    yo  = ty * TH;
    y0  = (yo - HALO < 0) ? 0 : yo - HALO;
    y1  = (yo + TH - 1 + HALO > IH - 1) ? IH - 1 : yo + TH - 1 + HALO;
    xs  = (xo - PPC < 0) ? 0 : xo - PPC;
    xe  = (xo + TW + PPC > IW) ? IW : xo + TW + PPC;
    len = (xe - xs) / PPC;
    pad = ((ty == 0) ? 8 : 0) | ((ty == NTY - 1) ? 4 : 0) | ((tx == 0) ? 2 : 0) | ((tx == NTX - 1) ? 1 : 0);
  endfunction

  function automatic int exp_cfg(input int t);
    int y0, y1, xs, len, pad;
    tile_geom(t, y0, y1, xs, len, pad);
    return ((t % NTX) << 16) | ((t / NTX) << 8) | pad;
  endfunction

  task automatic build_model();
    int y0, y1, xs, len, pad;
    for (int t = 0; t < NT; t++) begin
      tile_geom(t, y0, y1, xs, len, pad);
      for (int yy = y0; yy <= y1; yy++) begin
        exp_addr.push_back(yy * IW + xs);
        exp_len.push_back(len);
        exp_tile.push_back(t);
      end
    end
  endtask

  // Monitor: captures handshakes, checks protocol rules, schedules eng_done.
  always @(negedge clk) begin
    int y0, y1, xs, len, pad;
    if (rst) begin
      tile_idx = -1; rows_seen = 0; eng_cd = 0; eng_go = 0;
      prev_req_stall = 0; prev_cfg_stall = 0; prev_done = 0; prev_busy = 0;
    end else begin
      if (req_valid && cfg_valid) viol_both++;
      if (prev_req_stall && !(req_valid && int'(req_addr) == prev_addr && int'(req_len) == prev_len))
        viol_stab++;
      if (prev_cfg_stall && !(cfg_valid && {8'h0, cfg_tx, cfg_ty, 4'h0, cfg_pad} == prev_cfg))
        viol_stab++;
      if (done && prev_done) viol_done++;
      if (done) done_cnt++;
      if (busy && !prev_busy) tile_idx = -1;
      eng_go = 0;
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) eng_go = 1;
      end
      if (cfg_valid && cfg_ready) begin
        tile_idx++;
        rows_seen = 0;
        cap_cfg.push_back({8'h0, cfg_tx, cfg_ty, 4'h0, cfg_pad});
        tile_geom(tile_idx, y0, y1, xs, len, pad);
        rows_need = y1 - y0 + 1;
      end
      if (req_valid && req_ready) begin
        cap_addr.push_back(int'(req_addr));
        cap_len.push_back(int'(req_len));
        cap_tile.push_back(tile_idx);
        rows_seen++;
        if (rows_seen == rows_need) eng_cd = 5;
      end
      prev_req_stall = req_valid && !req_ready;
      prev_cfg_stall = cfg_valid && !cfg_ready;
      prev_addr = int'(req_addr);
      prev_len  = int'(req_len);
      prev_cfg  = {8'h0, cfg_tx, cfg_ty, 4'h0, cfg_pad};
      prev_done = done;
      prev_busy = busy;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    cfg_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(posedge clk); #2;
    eng_done = eng_force | (eng_auto & eng_go);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (done_cnt > base);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, done, req_valid, cfg_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, req_valid, cfg_valid});
    end
    checks++;
    if (req_addr !== 14'd0 || req_len !== 8'd0) begin
      errors++; $display("FAIL reset_req got addr %0d len %0d want 0 0", req_addr, req_len);
    end
    checks++;
    if (cfg_tx !== 8'd0 || cfg_ty !== 8'd0 || cfg_pad !== 4'd0 || tiles_done !== 16'd0) begin
      errors++; $display("FAIL reset_cfg got tx %0d ty %0d pad %b tiles %0d want 0", cfg_tx, cfg_ty, cfg_pad, tiles_done);
    end
    tick(); rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++; $display("FAIL idle_hold got busy %b cfg_valid %b want 0 0", busy, cfg_valid);
    end
  endtask

  task automatic test_full_pass();
    int br, bc, bd, bs, bb, n, t0, first5, last;
    bit ok;
    rdy_rand = 0; eng_auto = 1;
    br = cap_addr.size(); bc = cap_cfg.size(); bd = done_cnt; bs = viol_stab; bb = viol_both;
    pulse_start();
    wait_done(5000, bd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_done_timeout got no done want done"); end
    repeat (2) @(negedge clk);
    checks++;
    if (cap_cfg.size() - bc !== NT) begin
      errors++; $display("FAIL full_cfg_count got %0d want %0d", cap_cfg.size() - bc, NT);
    end
    n = cap_addr.size() - br;
    checks++;
    if (n !== exp_addr.size()) begin
      errors++; $display("FAIL full_req_count got %0d want %0d", n, exp_addr.size());
    end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if (cap_addr[br+i] !== exp_addr[i] || cap_len[br+i] !== exp_len[i] || cap_tile[br+i] !== exp_tile[i]) begin
        errors++; $display("FAIL full_req[%0d] got addr %0d len %0d tile %0d want %0d %0d %0d",
                           i, cap_addr[br+i], cap_len[br+i], cap_tile[br+i], exp_addr[i], exp_len[i], exp_tile[i]);
      end
    end
    for (int i = 0; i < NT && bc + i < cap_cfg.size(); i++) begin
      checks++;
      if (cap_cfg[bc+i] !== exp_cfg(i)) begin
        errors++; $display("FAIL full_cfg[%0d] got %h want %h", i, cap_cfg[bc+i], exp_cfg(i));
      end
    end
    t0 = 0; first5 = -1; last = -1;
    for (int i = br; i < cap_addr.size(); i++) begin
      if (cap_tile[i] == 0) t0++;
      if (cap_tile[i] == 5 && first5 < 0) first5 = i;
      last = i;
    end
    checks++;
    if (t0 !== 33 || (n > 32 && (cap_addr[br] !== 0 || cap_addr[br+32] !== 4096 || cap_len[br] !== 5))) begin
      errors++; $display("FAIL tile00 got %0d rows want 33 rows addr 0..4096 len 5", t0);
    end
    checks++;
    if (first5 < 0 || cap_addr[first5] !== 3992 || cap_len[first5] !== 6) begin
      errors++; $display("FAIL tile11_first got idx %0d want addr 3992 len 6", first5);
    end
    checks++;
    if (last < 0 || cap_addr[last] !== 16344 || cap_len[last] !== 5) begin
      errors++; $display("FAIL tile33_last got idx %0d want addr 16344 len 5", last);
    end
    checks++;
    if (cap_cfg.size() - bc >= NT && (cap_cfg[bc+5][3:0] !== 4'b0000 || cap_cfg[bc+15][3:0] !== 4'b0101)) begin
      errors++; $display("FAIL pad got t5 %b t15 %b want 0000 0101", cap_cfg[bc+5][3:0], cap_cfg[bc+15][3:0]);
    end
    checks++;
    if (done_cnt - bd !== 1 || viol_done !== 0) begin
      errors++; $display("FAIL done_pulse got %0d pulses %0d long want 1 0", done_cnt - bd, viol_done);
    end
    checks++;
    if (tiles_done !== 16'd16 || busy !== 1'b0) begin
      errors++; $display("FAIL full_end got tiles %0d busy %b want 16 0", tiles_done, busy);
    end
    checks++;
    if (viol_stab != bs || viol_both != bb) begin
      errors++; $display("FAIL full_proto got stab %0d both %0d want 0 0", viol_stab - bs, viol_both - bb);
    end
  endtask

  task automatic test_random_ready();
    int br, bd, bs, bb, n;
    bit ok;
    rdy_rand = 1; eng_auto = 1;
    br = cap_addr.size(); bd = done_cnt; bs = viol_stab; bb = viol_both;
    pulse_start();
    wait_done(20000, bd, ok);
    rdy_rand = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_done_timeout got no done want done"); end
    repeat (2) @(negedge clk);
    n = cap_addr.size() - br;
    checks++;
    if (n !== 536) begin errors++; $display("FAIL rand_req_count got %0d want 536", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if (cap_addr[br+i] !== exp_addr[i] || cap_len[br+i] !== exp_len[i]) begin
        errors++; $display("FAIL rand_req[%0d] got addr %0d len %0d want %0d %0d",
                           i, cap_addr[br+i], cap_len[br+i], exp_addr[i], exp_len[i]);
      end
    end
    checks++;
    if (viol_stab != bs || viol_both != bb) begin
      errors++; $display("FAIL rand_stall_stable got stab %0d both %0d want 0 0", viol_stab - bs, viol_both - bb);
    end
    checks++;
    if (tiles_done !== 16'd16 || done_cnt - bd !== 1) begin
      errors++; $display("FAIL rand_end got tiles %0d done %0d want 16 1", tiles_done, done_cnt - bd);
    end
  endtask

  task automatic test_reset_mid();
    int br, bc, bd;
    bit ok, hit;
    eng_auto = 1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (tile_idx == 5 && rows_seen >= 3 && req_valid);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_tile5 got tile %0d want 5 in fetch", tile_idx); end
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({busy, done, req_valid, cfg_valid} !== 4'b0 || req_addr !== 14'd0 || req_len !== 8'd0) begin
      errors++; $display("FAIL mid_rst_req got ctrl %b addr %0d len %0d want 0", {busy, done, req_valid, cfg_valid}, req_addr, req_len);
    end
    checks++;
    if (cfg_tx !== 8'd0 || cfg_ty !== 8'd0 || cfg_pad !== 4'd0 || tiles_done !== 16'd0) begin
      errors++; $display("FAIL mid_rst_cfg got tx %0d ty %0d pad %b tiles %0d want 0", cfg_tx, cfg_ty, cfg_pad, tiles_done);
    end
    tick(); rst = 1'b0;
    br = cap_addr.size(); bc = cap_cfg.size(); bd = done_cnt;
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cfg_valid !== 1'b1 || {cfg_tx, cfg_ty, cfg_pad} !== {8'd0, 8'd0, 4'b1010} || tiles_done !== 16'd0) begin
      errors++; $display("FAIL mid_restart got busy %b cfg %b tx %0d ty %0d pad %b tiles %0d want 1 1 0 0 1010 0",
                         busy, cfg_valid, cfg_tx, cfg_ty, cfg_pad, tiles_done);
    end
    wait_done(5000, bd, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || cap_addr.size() - br !== 536 || tiles_done !== 16'd16) begin
      errors++; $display("FAIL mid_rerun got done %b reqs %0d tiles %0d want 1 536 16", ok, cap_addr.size() - br, tiles_done);
    end
  endtask

  task automatic test_ignore();
    int c0, bd;
    bit hit, ok;
    eng_auto = 0;
    bd = done_cnt;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (tile_idx == 0 && rows_seen == 33 && !req_valid);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL ign_reach_wait got rows %0d want 33", rows_seen); end
    repeat (2) tick();
    c0 = cap_cfg.size();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (cap_cfg.size() !== c0 || busy !== 1'b1 || req_valid !== 1'b0 || cfg_valid !== 1'b0 || tiles_done !== 16'd0) begin
      errors++; $display("FAIL start_in_wait got cfgs %0d busy %b rv %b cv %b tiles %0d want %0d 1 0 0 0",
                         cap_cfg.size(), busy, req_valid, cfg_valid, tiles_done, c0);
    end
    tick(); eng_force = 1;
    tick(); eng_force = 0;
    @(negedge clk);
    checks++;
    if (tiles_done !== 16'd1 || cfg_valid !== 1'b1 || cfg_tx !== 8'd1) begin
      errors++; $display("FAIL eng_done_wait got tiles %0d cv %b tx %0d want 1 1 1", tiles_done, cfg_valid, cfg_tx);
    end
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (tile_idx == 1 && rows_seen == 33 && !req_valid);
    end
    tick(); start = 1'b1; eng_force = 1;
    tick(); start = 1'b0; eng_force = 0;
    @(negedge clk);
    checks++;
    if (tiles_done !== 16'd2 || cfg_valid !== 1'b1 || cfg_tx !== 8'd2 || cfg_ty !== 8'd0) begin
      errors++; $display("FAIL start_and_eng_done got tiles %0d cv %b tx %0d ty %0d want 2 1 2 0",
                         tiles_done, cfg_valid, cfg_tx, cfg_ty);
    end
    repeat (10) tick();
    eng_auto = 1;
    wait_done(5000, bd, ok);
    repeat (3) @(negedge clk);
    tick(); eng_force = 1;
    tick(); eng_force = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || tiles_done !== 16'd16 || busy !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++; $display("FAIL eng_done_idle got done %b tiles %0d busy %b cv %b want 1 16 0 0", ok, tiles_done, busy, cfg_valid);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_full_pass();
    test_random_ready();
    test_reset_mid();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
